// File: rtl/alu16_sequencer.sv
// Sequences 8- and 16-bit Z80 add/subtract style ops onto one shared 8-bit alu,
// chaining carry from the low-byte cycle into the high-byte cycle.
package alu16_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    INC = 3'd4,
    DEC = 3'd5
  } alu_op;
endpackage

module alu16_sequencer
  import alu16_pkg::*;
#(
  parameter int byte_width = 8,
  parameter int flag_c_bit = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    wide,
  input  alu_op                   opcode,
  input  logic [2*byte_width-1:0] op_a,
  input  logic [2*byte_width-1:0] op_b,
  input  logic                    carry_in,
  output logic                    busy,
  output logic                    done,
  output logic [2*byte_width-1:0] result,
  output logic [7:0]              flags_out,
  output logic [7:0]              flags_mask,
  output logic [byte_width-1:0]   alu_a,
  output logic [byte_width-1:0]   alu_b,
  output alu_op                   alu_opcode,
  output logic                    alu_cin,
  output logic                    alu_enable,
  input  logic [byte_width-1:0]   alu_out,
  input  logic [7:0]              alu_status
);

  localparam int flag_z_bit = 6;
  localparam int flag_n_bit = 1;
  localparam int bw = byte_width;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t              state_reg, state_next;
  alu_op               op_reg;
  logic                wide_reg;
  logic [2*bw-1:0]     a_reg, b_reg;
  logic                cin_reg;
  logic [bw-1:0]       res_lo_reg;
  logic                lo_z_reg, lo_c_reg;
  logic [2*bw-1:0]     result_reg, result_next;
  logic [7:0]          flags_reg, flags_next;
  logic [7:0]          mask_reg, mask_next;
  logic [7:0]          wide_mask, wide_flags;
  logic                last_cycle, step_op;

  // INC/DEC step by one in the low byte and only ripple carry/borrow upward
  assign step_op    = (op_reg == INC) || (op_reg == DEC);
  assign last_cycle = ((state_reg == S_LO) && !wide_reg) || (state_reg == S_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      op_reg     <= ADD;
      wide_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      res_lo_reg <= '0;
      lo_z_reg   <= 1'b0;
      lo_c_reg   <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && start) begin
        op_reg   <= opcode;
        wide_reg <= wide;
        a_reg    <= op_a;
        b_reg    <= op_b;
        cin_reg  <= carry_in;
      end
      if (state_reg == S_LO) begin
        res_lo_reg <= alu_out;
        lo_z_reg   <= alu_status[flag_z_bit];
        lo_c_reg   <= alu_status[flag_c_bit];
      end
      if (last_cycle) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
        mask_reg   <= mask_next;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    alu_enable = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = ADD;
    alu_cin    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LO;
      end
      S_LO: begin
        busy       = 1'b1;
        alu_enable = 1'b1;
        alu_a      = a_reg[bw-1:0];
        alu_b      = step_op ? {{(bw-1){1'b0}}, 1'b1} : b_reg[bw-1:0];
        case (op_reg)
          ADC: begin
            alu_opcode = ADC;
            alu_cin    = cin_reg;
          end
          SUB, DEC: alu_opcode = SUB;
          SBC: begin
            alu_opcode = SBC;
            alu_cin    = cin_reg;
          end
          default: alu_opcode = ADD;
        endcase
        state_next = wide_reg ? S_HI : S_DONE;
      end
      S_HI: begin
        busy       = 1'b1;
        alu_enable = 1'b1;
        alu_a      = a_reg[2*bw-1:bw];
        alu_b      = step_op ? '0 : b_reg[2*bw-1:bw];
        alu_opcode = (op_reg == ADD || op_reg == ADC || op_reg == INC) ? ADC : SBC;
        alu_cin    = lo_c_reg;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (op_reg)
      ADD:      wide_mask = 8'h13;
      INC, DEC: wide_mask = 8'h00;
      default:  wide_mask = 8'hD7;
    endcase
  end

  // Wide flags come from the high byte, except Z which must cover both bytes
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wflag
      if (gi == flag_z_bit) begin : g_z
        assign wide_flags[gi] = wide_mask[gi] & lo_z_reg & alu_status[gi];
      end else if (gi == flag_n_bit) begin : g_n
        assign wide_flags[gi] = wide_mask[gi] & alu_status[gi] & (op_reg != ADD);
      end else begin : g_o
        assign wide_flags[gi] = wide_mask[gi] & alu_status[gi];
      end
    end
  endgenerate

  always_comb begin
    if (wide_reg) begin
      result_next = {alu_out, res_lo_reg};
      flags_next  = wide_flags;
      mask_next   = wide_mask;
    end else begin
      result_next = {{bw{1'b0}}, alu_out};
      flags_next  = alu_status;
      mask_next   = 8'hFF;
    end
  end

  assign result     = result_reg;
  assign flags_out  = flags_reg;
  assign flags_mask = mask_reg;

endmodule
